// File: rtl/pu_or1k_ticktimer_arbiter.sv
// ---------------------------------------------------------------------------
// pu_or1k_ticktimer_arbiter
//
// Arbitrates two requesters (CPU core and debug unit) onto the single
// tick-timer SPR slave port. One access at a time: IDLE -> BUSY -> RESP.
// A BUSY access that the slave never acknowledges is ended by a timeout and
// reported through the requester's err flag.
//
// Configuration macro: OR1K_TT_ARB_RR_EN
//   defined   : round-robin between core and dbg when both request together
//   undefined : dbg wins every tie (fixed priority)
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycles allowed without slave ack (2..255)
//
// Ports:
//   clk, rst                        clock, async active-low reset
//   core_* / dbg_* (in)             req, we, 16-bit addr, 32-bit write data
//   core_* / dbg_* (out)            one-cycle ack, err, 32-bit read data
//   spr_access_o, spr_we_o          slave access / write strobe (BUSY only)
//   spr_addr_o, spr_dat_o           slave address / write data
//   spr_bus_ack_i, spr_dat_i        slave acknowledge / read data
// ---------------------------------------------------------------------------
module pu_or1k_ticktimer_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [15:0] core_addr_i,
   input  logic [31:0] core_dat_i,
   input  logic        dbg_req_i,
   input  logic        dbg_we_i,
   input  logic [15:0] dbg_addr_i,
   input  logic [31:0] dbg_dat_i,
   output logic        core_ack_o,
   output logic        core_err_o,
   output logic [31:0] core_dat_o,
   output logic        dbg_ack_o,
   output logic        dbg_err_o,
   output logic [31:0] dbg_dat_o,
   output logic        spr_access_o,
   output logic        spr_we_o,
   output logic [15:0] spr_addr_o,
   output logic [31:0] spr_dat_o,
   input  logic        spr_bus_ack_i,
   input  logic [31:0] spr_dat_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q,      state_d;
   logic [7:0]  cnt_q,        cnt_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_dbg_q,  grant_dbg_d;
   logic        spr_access_q, spr_access_d;
   logic        spr_we_q,     spr_we_d;
   logic [15:0] spr_addr_q,   spr_addr_d;
   logic [31:0] spr_dat_q,    spr_dat_d;
   logic        core_ack_q,   core_ack_d;
   logic        core_err_q,   core_err_d;
   logic [31:0] core_dat_q,   core_dat_d;
   logic        dbg_ack_q,    dbg_ack_d;
   logic        dbg_err_q,    dbg_err_d;
   logic [31:0] dbg_dat_q,    dbg_dat_d;

   logic        pick_dbg_s;
   logic        go_resp_s;
   logic        resp_err_s;
   logic [31:0] resp_dat_s;

   // Winner selection, evaluated only when a grant happens in IDLE
   always_comb begin
      pick_dbg_s = 1'b0;
`ifdef OR1K_TT_ARB_RR_EN
      if (core_req_i && dbg_req_i) begin
         pick_dbg_s = ~last_grant_q;
      end else begin
         pick_dbg_s = dbg_req_i;
      end
`else
      // last_grant_q is still tracked but plays no part in the decision
      pick_dbg_s = dbg_req_i;
`endif
   end

   // Next-state and output computation for the IDLE/BUSY/RESP sequence
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_dbg_d  = grant_dbg_q;
      spr_access_d = 1'b0;
      spr_we_d     = 1'b0;
      spr_addr_d   = spr_addr_q;
      spr_dat_d    = spr_dat_q;
      core_ack_d   = 1'b0;
      core_err_d   = 1'b0;
      core_dat_d   = 32'd0;
      dbg_ack_d    = 1'b0;
      dbg_err_d    = 1'b0;
      dbg_dat_d    = 32'd0;
      go_resp_s    = 1'b0;
      resp_err_s   = 1'b0;
      resp_dat_s   = 32'd0;

      case (state_q)
         ST_IDLE: begin
            if (core_req_i || dbg_req_i) begin
               grant_dbg_d  = pick_dbg_s;
               last_grant_d = pick_dbg_s;
               spr_we_d     = pick_dbg_s ? dbg_we_i   : core_we_i;
               spr_addr_d   = pick_dbg_s ? dbg_addr_i : core_addr_i;
               spr_dat_d    = pick_dbg_s ? dbg_dat_i  : core_dat_i;
               spr_access_d = 1'b1;
               cnt_d        = 8'd0;
               state_d      = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // A slave ack in the final allowed cycle beats the timeout
            if (spr_bus_ack_i) begin
               go_resp_s  = 1'b1;
               resp_err_s = 1'b0;
               resp_dat_s = spr_we_q ? 32'd0 : spr_dat_i;
            end else if (cnt_q == TIMEOUT_LAST) begin
               go_resp_s  = 1'b1;
               resp_err_s = 1'b1;
               resp_dat_s = 32'd0;
            end else begin
               cnt_d        = cnt_q + 8'd1;
               spr_access_d = 1'b1;
               spr_we_d     = spr_we_q;
            end
            if (go_resp_s) begin
               state_d    = ST_RESP;
               core_ack_d = ~grant_dbg_q;
               core_err_d = ~grant_dbg_q & resp_err_s;
               core_dat_d = grant_dbg_q ? 32'd0 : resp_dat_s;
               dbg_ack_d  = grant_dbg_q;
               dbg_err_d  = grant_dbg_q & resp_err_s;
               dbg_dat_d  = grant_dbg_q ? resp_dat_s : 32'd0;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         last_grant_q <= 1'b1;
         grant_dbg_q  <= 1'b0;
         spr_access_q <= 1'b0;
         spr_we_q     <= 1'b0;
         spr_addr_q   <= 16'd0;
         spr_dat_q    <= 32'd0;
         core_ack_q   <= 1'b0;
         core_err_q   <= 1'b0;
         core_dat_q   <= 32'd0;
         dbg_ack_q    <= 1'b0;
         dbg_err_q    <= 1'b0;
         dbg_dat_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_dbg_q  <= grant_dbg_d;
         spr_access_q <= spr_access_d;
         spr_we_q     <= spr_we_d;
         spr_addr_q   <= spr_addr_d;
         spr_dat_q    <= spr_dat_d;
         core_ack_q   <= core_ack_d;
         core_err_q   <= core_err_d;
         core_dat_q   <= core_dat_d;
         dbg_ack_q    <= dbg_ack_d;
         dbg_err_q    <= dbg_err_d;
         dbg_dat_q    <= dbg_dat_d;
      end
   end

   assign spr_access_o = spr_access_q;
   assign spr_we_o     = spr_we_q;
   assign spr_addr_o   = spr_addr_q;
   assign spr_dat_o    = spr_dat_q;
   assign core_ack_o   = core_ack_q;
   assign core_err_o   = core_err_q;
   assign core_dat_o   = core_dat_q;
   assign dbg_ack_o    = dbg_ack_q;
   assign dbg_err_o    = dbg_err_q;
   assign dbg_dat_o    = dbg_dat_q;

endmodule

// File: tb/tb_pu_or1k_ticktimer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pu_or1k_ticktimer_arbiter
//
// Directed bench for the tick-timer SPR arbiter. Inputs change on the
// falling edge; outputs are sampled on the falling edge. The slave is a
// small model whose ack is immediate, never, or delayed by a fixed number
// of BUSY cycles. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pu_or1k_ticktimer_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        core_req_i = 1'b0, core_we_i = 1'b0;
   logic [15:0] core_addr_i = 16'd0;
   logic [31:0] core_dat_i = 32'd0;
   logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
   logic [15:0] dbg_addr_i = 16'd0;
   logic [31:0] dbg_dat_i = 32'd0;
   logic        core_ack_o, core_err_o, dbg_ack_o, dbg_err_o;
   logic [31:0] core_dat_o, dbg_dat_o;
   logic        spr_access_o, spr_we_o;
   logic [15:0] spr_addr_o;
   logic [31:0] spr_dat_o;
   logic        spr_bus_ack_i;
   logic [31:0] spr_dat_i;

   // slave model: mode 0 = immediate ack, 1 = never, 2 = ack after ack_delay BUSY cycles
   int          slave_mode = 0;
   int          ack_delay  = 0;
   int          busy_cnt   = 0;
   logic [31:0] slave_rdata = 32'h0000_1234;

   int n_checks = 0;
   int n_errors = 0;

   logic        last_we;
   logic [15:0] last_addr;
   logic [31:0] last_wdat;

   pu_or1k_ticktimer_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .core_req_i(core_req_i), .core_we_i(core_we_i),
      .core_addr_i(core_addr_i), .core_dat_i(core_dat_i),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
      .dbg_addr_i(dbg_addr_i), .dbg_dat_i(dbg_dat_i),
      .core_ack_o(core_ack_o), .core_err_o(core_err_o), .core_dat_o(core_dat_o),
      .dbg_ack_o(dbg_ack_o), .dbg_err_o(dbg_err_o), .dbg_dat_o(dbg_dat_o),
      .spr_access_o(spr_access_o), .spr_we_o(spr_we_o),
      .spr_addr_o(spr_addr_o), .spr_dat_o(spr_dat_o),
      .spr_bus_ack_i(spr_bus_ack_i), .spr_dat_i(spr_dat_i)
   );

   always #5 clk = ~clk;

   assign spr_dat_i     = slave_rdata;
   assign spr_bus_ack_i = spr_access_o &&
                          ((slave_mode == 0) || ((slave_mode == 2) && (busy_cnt == ack_delay)));

   // Count consecutive BUSY cycles seen by the slave model
   always @(posedge clk or negedge rst) begin
      if (!rst) busy_cnt <= 0;
      else      busy_cnt <= spr_access_o ? busy_cnt + 1 : 0;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for either ack; n = falling edges waited, acc = access cycles seen
   task automatic wait_ack(input int budget, output int n, output int acc);
      logic seen;
      seen = 1'b0;
      n = 0;
      acc = 0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (core_ack_o || dbg_ack_o) begin
            seen = 1'b1;
         end else if (spr_access_o) begin
            acc++;
            last_we   = spr_we_o;
            last_addr = spr_addr_o;
            last_wdat = spr_dat_o;
         end
      end
      check_value("ack_seen", {31'd0, seen}, 32'd1);
   endtask

   int n, acc, acks;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check_value("rst_core_ack", {31'd0, core_ack_o}, 32'd0);
      check_value("rst_dbg_ack", {31'd0, dbg_ack_o}, 32'd0);
      check_value("rst_access", {31'd0, spr_access_o}, 32'd0);
      check_value("rst_we", {31'd0, spr_we_o}, 32'd0);
      check_value("rst_addr", {16'd0, spr_addr_o}, 32'd0);
      check_value("rst_wdat", spr_dat_o, 32'd0);
      check_value("rst_core_dat", core_dat_o, 32'd0);
      check_value("rst_errs", {30'd0, core_err_o, dbg_err_o}, 32'd0);
      rst = 1'b1;

      // core write, immediate slave ack
      @(negedge clk);
      slave_mode = 0;
      core_req_i = 1'b1; core_we_i = 1'b1;
      core_addr_i = 16'h5000; core_dat_i = 32'h4000_00FF;
      wait_ack(10, n, acc);
      core_req_i = 1'b0;
      check_value("wr_latency", n, 32'd2);
      check_value("wr_access_cycles", acc, 32'd1);
      check_value("wr_spr_we", {31'd0, last_we}, 32'd1);
      check_value("wr_spr_addr", {16'd0, last_addr}, 32'h0000_5000);
      check_value("wr_spr_dat", last_wdat, 32'h4000_00FF);
      check_value("wr_core_ack", {31'd0, core_ack_o}, 32'd1);
      check_value("wr_core_dat", core_dat_o, 32'd0);
      check_value("wr_core_err", {31'd0, core_err_o}, 32'd0);
      check_value("wr_dbg_ack", {31'd0, dbg_ack_o}, 32'd0);
      @(negedge clk);
      check_value("wr_ack_one_cycle", {31'd0, core_ack_o}, 32'd0);

      // dbg read, slave returns 0x1234
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 16'h5001;
      wait_ack(10, n, acc);
      dbg_req_i = 1'b0;
      check_value("rd_latency", n, 32'd2);
      check_value("rd_spr_addr", {16'd0, last_addr}, 32'h0000_5001);
      check_value("rd_spr_we", {31'd0, last_we}, 32'd0);
      check_value("rd_dbg_ack", {31'd0, dbg_ack_o}, 32'd1);
      check_value("rd_dbg_dat", dbg_dat_o, 32'h0000_1234);
      check_value("rd_dbg_err", {31'd0, dbg_err_o}, 32'd0);
      check_value("rd_core_side", {core_ack_o, core_err_o, 30'd0} | core_dat_o, 32'd0);
      @(negedge clk);

      // both requesting continuously; last grant was dbg
      core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 16'h5004;
      dbg_req_i  = 1'b1; dbg_we_i  = 1'b0; dbg_addr_i  = 16'h5005;
      for (int k = 0; k < 4; k++) begin
         wait_ack(10, n, acc);
`ifdef OR1K_TT_ARB_RR_EN
         check_value($sformatf("both_winner_dbg_%0d", k), {31'd0, dbg_ack_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
`else
         check_value($sformatf("both_winner_dbg_%0d", k), {31'd0, dbg_ack_o}, 32'd1);
`endif
         check_value($sformatf("both_single_ack_%0d", k), {31'd0, core_ack_o ^ dbg_ack_o}, 32'd1);
         if (k > 0) check_value($sformatf("both_spacing_%0d", k), n, 32'd3);
      end
      core_req_i = 1'b0; dbg_req_i = 1'b0;
      @(negedge clk);

      // core read with slave never acking: timeout after 16 BUSY cycles
      slave_mode = 1; slave_rdata = 32'hA5A5_A5A5;
      core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 16'h5003;
      wait_ack(40, n, acc);
      core_req_i = 1'b0;
      check_value("to_access_cycles", acc, 32'd16);
      check_value("to_latency", n, 32'd17);
      check_value("to_core_ack", {31'd0, core_ack_o}, 32'd1);
      check_value("to_core_err", {31'd0, core_err_o}, 32'd1);
      check_value("to_core_dat", core_dat_o, 32'd0);
      @(negedge clk);

      // dbg write, slave acks on the 4th BUSY cycle; dbg drops req mid-BUSY
      slave_mode = 2; ack_delay = 3;
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 16'h5002; dbg_dat_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_value($sformatf("dly_access_%0d", i), {31'd0, spr_access_o}, 32'd1);
         check_value($sformatf("dly_we_%0d", i), {31'd0, spr_we_o}, 32'd1);
         check_value($sformatf("dly_addr_%0d", i), {16'd0, spr_addr_o}, 32'h0000_5002);
         check_value($sformatf("dly_dat_%0d", i), spr_dat_o, 32'hDEAD_BEEF);
         if (i == 1) begin
            dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = 16'h0BAD; dbg_dat_i = 32'd0;
         end
      end
      @(negedge clk);
      check_value("dly_dbg_ack", {31'd0, dbg_ack_o}, 32'd1);
      check_value("dly_dbg_err", {31'd0, dbg_err_o}, 32'd0);
      check_value("dly_dbg_dat", dbg_dat_o, 32'd0);
      check_value("dly_access_off", {31'd0, spr_access_o}, 32'd0);
      @(negedge clk);
      check_value("dly_ack_one_cycle", {31'd0, dbg_ack_o}, 32'd0);

      // reset asserted during BUSY aborts the access
      slave_mode = 1;
      core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 16'h5006; core_dat_i = 32'h0000_0077;
      repeat (2) @(negedge clk);
      check_value("rb_access_before", {31'd0, spr_access_o}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check_value("rb_access_async", {31'd0, spr_access_o}, 32'd0);
      check_value("rb_we_async", {31'd0, spr_we_o}, 32'd0);
      check_value("rb_addr_async", {16'd0, spr_addr_o}, 32'd0);
      check_value("rb_dat_async", spr_dat_o, 32'd0);
      core_req_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (core_ack_o || dbg_ack_o || spr_access_o) acks++;
      end
      check_value("rb_no_ack_after", acks, 32'd0);
      slave_mode = 0; slave_rdata = 32'h0000_4321;
      core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 16'h5006;
      wait_ack(10, n, acc);
      core_req_i = 1'b0;
      check_value("rb_reissue_latency", n, 32'd2);
      check_value("rb_reissue_ack", {31'd0, core_ack_o}, 32'd1);
      check_value("rb_reissue_dat", core_dat_o, 32'h0000_4321);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pu_or1k_ticktimer_arbiter.md
PU_OR1K_TICKTIMER_ARBITER -- requirements
Module: pu_or1k_ticktimer_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles in BUSY without a slave ack before an error response; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous assertion, active-low (rst=0 resets).
REQ-004 core_req_i / dbg_req_i  input  1 each  requester access request, held until the matching ack.
REQ-005 core_we_i / dbg_we_i  input  1 each  write enable qualifying the request.
REQ-006 core_addr_i / dbg_addr_i  input  16 each  SPR address.
REQ-007 core_dat_i / dbg_dat_i  input  32 each  SPR write data.
REQ-008 core_ack_o / dbg_ack_o  output  1 each  one-cycle completion pulse.
REQ-009 core_err_o / dbg_err_o  output  1 each  timeout flag, valid only while the matching ack is high.
REQ-010 core_dat_o / dbg_dat_o  output  32 each  read data, valid only while the matching ack is high.
REQ-011 spr_access_o, spr_we_o  output  1 each  timer SPR access and write strobe.
REQ-012 spr_addr_o, spr_dat_o  output  16, 32  timer SPR address and write data.
REQ-013 spr_bus_ack_i  input  1  slave acknowledge; combinational in the same cycle as spr_access_o is permitted.
REQ-014 spr_dat_i  input  32  slave read data, valid with spr_bus_ack_i.

Function
REQ-015 FSM states: IDLE, BUSY, RESP; encoding is free.
- IDLE: when any request is high, select a winner, register its we/addr/dat into the spr_*_o registers, go to BUSY.
- IDLE with no request: stay in IDLE.
REQ-016 BUSY: spr_access_o=1, and spr_we_o/addr/dat are held constant for the entire BUSY period.
REQ-017 BUSY with spr_bus_ack_i=1: capture spr_dat_i, or 0 if spr_we_o=1; set err=0; go to RESP.
REQ-018 BUSY timeout counter: 8 bits, cleared on entry to BUSY, incremented each BUSY cycle without an ack.
- When the count reaches TIMEOUT_CYCLES-1 with no ack: capture data=0, err=1, go to RESP.
- An ack in that same cycle wins over the timeout (err=0).
REQ-019 RESP: for exactly one cycle, pulse the winner's ack, drive its dat/err, then go to IDLE.
- The other requester's ack, err and dat stay 0.
REQ-020 Latency: request seen in IDLE at cycle N, combinational slave ack gives requester ack at cycle N+2; back-to-back throughput is one access per 3 cycles.
REQ-021 Requests are evaluated only in IDLE. A request that rises or changes during BUSY or RESP waits; nothing is preempted.
REQ-022 Requester signals are registered at grant; a requester dropping req during BUSY still receives its ack pulse.
REQ-023 spr_access_o=0 in IDLE and RESP; spr_we_o is gated to 0 outside BUSY.
REQ-024 Register last_grant (0=core, 1=dbg) is updated at each grant.

Reset
REQ-025 While rst=0:
- state=IDLE, timeout counter=0, last_grant=1.
- All ack/err/access/we outputs=0; all addr/dat outputs=0.
REQ-026 Reset asserted mid-access aborts the access with no ack. Requesters reissue after reset release.
REQ-027 On the first clk edge after rst deasserts, the FSM may grant.

Configuration
REQ-028 Macro OR1K_TT_ARB_RR_EN defined: when both requests are high in IDLE, grant the requester that is not last_grant (round-robin).
REQ-029 Macro OR1K_TT_ARB_RR_EN undefined: when both are high, dbg always wins (fixed priority); last_grant is still maintained but ignored.
- A single request is granted identically in both builds.

Verification
REQ-030 core write addr 0x5000, data 0x4000_00FF, slave acks immediately:
- spr_access_o high 1 cycle with we=1, addr 0x5000.
- core_ack_o pulse at N+2 with core_dat_o=0, err=0.
REQ-031 dbg read addr 0x5001, slave acks in the same cycle with 0x0000_1234: dbg_ack_o at N+2, dbg_dat_o=0x0000_1234, core_ack_o stays 0.
REQ-032 Both request continuously, each reissuing after ack:
- With RR_EN: grants alternate core, dbg, core, dbg.
- Without RR_EN: dbg is granted every time.
REQ-033 core read with spr_bus_ack_i tied 0, TIMEOUT_CYCLES=16: spr_access_o high 16 cycles, then core_ack_o=1, core_err_o=1, core_dat_o=0.
REQ-034 Slave ack delayed 3 cycles: addr/dat/we are stable on all 4 BUSY cycles; ack 1 cycle later.
REQ-035 rst driven 0 during BUSY: outputs 0 immediately (asynchronous); no ack after release; a reissued request completes normally.
